// File: rtl/block_xfer_if.sv
// block_xfer_if: command port plus register-file and RAM access buses of block_xfer_seq
interface block_xfer_if #(parameter int DW = 4, parameter int AW = 4);
  logic cmd_valid, cmd_ready, abort, busy, done, aborted;
  logic [1:0] cmd_op;
  logic [AW-1:0] cmd_src, cmd_dst, reg_raddr, reg_waddr, ram_addr;
  logic [AW:0] cmd_len, xfer_cnt;
  logic [DW-1:0] cmd_fill, reg_rdata, reg_wdata, ram_rdata, ram_wdata;
  logic reg_rd, reg_we, ram_rd, ram_we;
  modport master (
    input  cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_len, cmd_fill, abort, reg_rdata, ram_rdata,
    output cmd_ready, busy, done, aborted, xfer_cnt, reg_rd, reg_raddr, reg_we, reg_waddr,
           reg_wdata, ram_rd, ram_we, ram_addr, ram_wdata
  );
  modport slave (
    output cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_len, cmd_fill, abort, reg_rdata, ram_rdata,
    input  cmd_ready, busy, done, aborted, xfer_cnt, reg_rd, reg_raddr, reg_we, reg_waddr,
           reg_wdata, ram_rd, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/block_xfer_seq.sv
// block_xfer_seq: handshaked block copy/fill sequencer driving a register file and RAM pair
module block_xfer_seq #(
  parameter int DW = 4,
  parameter int AW = 4,
  parameter int RD_LAT = 1
) (
  input logic clk,
  input logic rst,
  block_xfer_if.master b
);
  typedef enum logic [2:0] {IDLE, RD, WAIT, WR, DONE} state_t;
  state_t st, nst;
  logic [1:0] op, cop, lat;
  logic [AW-1:0] src, dst, ra, wa;
  logic [AW:0] rem;
  logic [DW-1:0] fill, wd;
  logic accept, active;
  // op[1] selects fill, op[0] selects RAM as destination (and REG as copy source)
  always_comb begin
    accept = st == IDLE && b.cmd_valid;
    active = st == RD || st == WAIT || st == WR;
    cop = accept ? b.cmd_op : op;
    ra = accept ? b.cmd_src : src + 1'b1;
    wa = accept ? b.cmd_dst : st == WR ? dst + 1'b1 : dst;
    wd = cop[1] ? (accept ? b.cmd_fill : fill) : op[0] ? b.reg_rdata : b.ram_rdata;
    nst = accept ? (b.cmd_len == '0 ? DONE : b.cmd_op[1] ? WR : RD) :
          st == RD ? (b.abort ? DONE : WAIT) :
          st == WAIT ? (b.abort ? DONE : lat == '0 ? WR : WAIT) :
          st == WR ? (b.abort || rem == (AW+1)'(1) ? DONE : op[1] ? WR : RD) :
          st == DONE ? IDLE : st;
  end
  // outputs are registered from the next state so each strobe lines up with its state
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st <= IDLE;
      op <= '0;
      src <= '0;
      dst <= '0;
      rem <= '0;
      fill <= '0;
      lat <= '0;
      b.cmd_ready <= 1'b1;
      b.busy <= 1'b0;
      b.done <= 1'b0;
      b.aborted <= 1'b0;
      b.xfer_cnt <= '0;
      b.reg_rd <= 1'b0;
      b.reg_we <= 1'b0;
      b.ram_rd <= 1'b0;
      b.ram_we <= 1'b0;
      b.reg_raddr <= '0;
      b.reg_waddr <= '0;
      b.reg_wdata <= '0;
      b.ram_addr <= '0;
      b.ram_wdata <= '0;
    end else begin
      st <= nst;
      lat <= st == WAIT ? lat - 1'b1 : 2'(RD_LAT - 1);
      if (accept) begin
        op <= b.cmd_op;
        src <= b.cmd_src;
        dst <= b.cmd_dst;
        rem <= b.cmd_len;
        fill <= b.cmd_fill;
        b.xfer_cnt <= '0;
      end
      if (st == WR) begin
        src <= src + 1'b1;
        dst <= dst + 1'b1;
        rem <= rem - 1'b1;
        b.xfer_cnt <= b.xfer_cnt + 1'b1;
      end
      b.aborted <= accept ? 1'b0 : b.aborted | (b.abort && active);
      b.cmd_ready <= nst == IDLE;
      b.busy <= nst != IDLE;
      b.done <= nst == DONE;
      b.reg_rd <= nst == RD && cop[0];
      b.ram_rd <= nst == RD && !cop[0];
      b.reg_we <= nst == WR && !cop[0];
      b.ram_we <= nst == WR && cop[0];
      if (nst == RD && cop[0]) b.reg_raddr <= ra;
      if (nst == WR && !cop[0]) begin
        b.reg_waddr <= wa;
        b.reg_wdata <= wd;
      end
      if (nst == RD && !cop[0]) b.ram_addr <= ra;
      else if (nst == WR && cop[0]) begin
        b.ram_addr <= wa;
        b.ram_wdata <= wd;
      end
    end
endmodule

// File: tb/tb_block_xfer_seq.sv
// tb_block_xfer_seq: scoreboard bench with memory models and an arithmetic reference of write order/timing
module tb_block_xfer_seq;
  localparam int DW = 4, AW = 4, RD_LAT = 2, N = 1 << AW, PER = 2 + RD_LAT;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  block_xfer_if #(.DW(DW), .AW(AW)) bus();
  block_xfer_seq #(.DW(DW), .AW(AW), .RD_LAT(RD_LAT)) dut (.clk(clk), .rst(rst), .b(bus));
  typedef struct {logic to_ram; logic [AW-1:0] a; logic [DW-1:0] d; int cyc;} wr_t;
  typedef struct {logic ab; logic [AW:0] cnt; int cyc;} end_t;
  wr_t wq[$];
  end_t eq[$];
  logic [DW-1:0] phys_reg [N], phys_ram [N], mdl_reg [N], mdl_ram [N];
  logic [AW:0] rp_reg [RD_LAT], rp_ram [RD_LAT];
  logic [DW-1:0] junk_d;
  int cyc = 0, cmp = 0, errs = 0;
  // memories answer reads exactly RD_LAT cycles later and return noise otherwise
  always @(posedge clk) begin
    cyc <= cyc + 1;
    junk_d <= DW'($urandom);
    if (rst) begin
      phys_reg <= mdl_reg;
      phys_ram <= mdl_ram;
    end else begin
      if (bus.reg_we) phys_reg[bus.reg_waddr] <= bus.reg_wdata;
      if (bus.ram_we) phys_ram[bus.ram_addr] <= bus.ram_wdata;
    end
    rp_reg[0] <= {bus.reg_rd, bus.reg_raddr};
    rp_ram[0] <= {bus.ram_rd, bus.ram_addr};
    for (int i = 1; i < RD_LAT; i++) begin
      rp_reg[i] <= rp_reg[i-1];
      rp_ram[i] <= rp_ram[i-1];
    end
  end
  assign bus.reg_rdata = rp_reg[RD_LAT-1][AW] ? phys_reg[rp_reg[RD_LAT-1][AW-1:0]] : junk_d;
  assign bus.ram_rdata = rp_ram[RD_LAT-1][AW] ? phys_ram[rp_ram[RD_LAT-1][AW-1:0]] : junk_d;
  wr_t mw;
  end_t me;
  int ns;
  always @(negedge clk) if (!rst) begin
    ns = int'(bus.reg_rd) + int'(bus.reg_we) + int'(bus.ram_rd) + int'(bus.ram_we);
    cmp++;
    if (ns > 1 || bus.busy == bus.cmd_ready) begin
      errs++;
      $display("FAIL strobes: got %0d strobes busy=%b ready=%b, need <=1 and busy!=ready", ns, bus.busy, bus.cmd_ready);
    end
    if (bus.reg_we || bus.ram_we) begin
      cmp++;
      if (wq.size() == 0) begin
        errs++;
        $display("FAIL write: unexpected write ram=%b cyc=%0d", bus.ram_we, cyc);
      end else begin
        mw = wq.pop_front();
        if ({bus.ram_we, bus.ram_we ? bus.ram_addr : bus.reg_waddr, bus.ram_we ? bus.ram_wdata : bus.reg_wdata, cyc} !==
            {mw.to_ram, mw.a, mw.d, mw.cyc}) begin
          errs++;
          $display("FAIL write: got ram=%b a=%h d=%h cyc=%0d, need ram=%b a=%h d=%h cyc=%0d", bus.ram_we,
                   bus.ram_we ? bus.ram_addr : bus.reg_waddr, bus.ram_we ? bus.ram_wdata : bus.reg_wdata, cyc,
                   mw.to_ram, mw.a, mw.d, mw.cyc);
        end
      end
    end
    if (bus.done) begin
      cmp++;
      if (eq.size() == 0) begin
        errs++;
        $display("FAIL done: unexpected done pulse cyc=%0d", cyc);
      end else begin
        me = eq.pop_front();
        if ({bus.aborted, bus.xfer_cnt, cyc} !== {me.ab, me.cnt, me.cyc}) begin
          errs++;
          $display("FAIL done: got aborted=%b cnt=%0d cyc=%0d, need aborted=%b cnt=%0d cyc=%0d",
                   bus.aborted, bus.xfer_cnt, cyc, me.ab, me.cnt, me.cyc);
        end
      end
    end
  end
  task automatic wait_ready(output bit ok);
    ok = 1'b1;
    @(negedge clk);
    for (int w = 0; !bus.cmd_ready; w++) begin
      if (w > 200) begin
        cmp++;
        errs++;
        $display("FAIL ready: got cmd_ready=0 for 200 cycles, need 1");
        ok = 1'b0;
        return;
      end
      @(negedge clk);
    end
  endtask
  // model: word i of a copy is written at offset i*PER+1+RD_LAT after accept, of a fill at offset i
  task automatic run(input logic [1:0] op, input logic [AW-1:0] src, dst, input logic [AW:0] len,
                     input logic [DW-1:0] fill, input int ab_at, input bit junk);
    int per, total, nw, dexp, acc;
    bit ab, ok;
    wait_ready(ok);
    if (!ok) return;
    per = op[1] ? 1 : PER;
    total = int'(len) * per;
    ab = ab_at >= 0 && ab_at < total;
    nw = !ab ? int'(len) : op[1] ? ab_at + 1 : (ab_at < 1 + RD_LAT ? 0 : (ab_at - 1 - RD_LAT) / per + 1);
    dexp = ab ? ab_at + 1 : total;
    acc = cyc + 1;
    for (int i = 0; i < nw; i++) begin
      wr_t w;
      logic [AW-1:0] s, d;
      s = src + AW'(i);
      d = dst + AW'(i);
      w.to_ram = op[0];
      w.a = d;
      w.cyc = acc + (op[1] ? i : i * per + 1 + RD_LAT);
      w.d = op[1] ? fill : op[0] ? mdl_reg[s] : mdl_ram[s];
      if (op[0]) mdl_ram[d] = w.d;
      else mdl_reg[d] = w.d;
      wq.push_back(w);
    end
    eq.push_back('{ab, (AW+1)'(nw), acc + dexp});
    bus.cmd_valid = 1'b1;
    bus.cmd_op = op;
    bus.cmd_src = src;
    bus.cmd_dst = dst;
    bus.cmd_len = len;
    bus.cmd_fill = fill;
    for (int k = 0; ; k++) begin
      @(negedge clk);
      bus.abort = k == ab_at;
      bus.cmd_valid = junk && k < dexp;
      bus.cmd_op = 2'($urandom);
      bus.cmd_len = (AW+1)'($urandom_range(0, N));
      if (bus.done) break;
      if (k > dexp + 4) begin
        cmp++;
        errs++;
        $display("FAIL done_timeout: got no done by offset %0d, need it at %0d", k, dexp);
        break;
      end
    end
    @(negedge clk);
    bus.abort = 1'b0;
    bus.cmd_valid = 1'b0;
    cmp++;
    if ({bus.xfer_cnt, bus.aborted} !== {(AW+1)'(nw), ab}) begin
      errs++;
      $display("FAIL hold: got cnt=%0d aborted=%b, need cnt=%0d aborted=%b", bus.xfer_cnt, bus.aborted, nw, ab);
    end
  endtask
  initial begin
    bit ok;
    bus.cmd_valid = 1'b0;
    bus.abort = 1'b0;
    bus.cmd_op = '0;
    bus.cmd_src = '0;
    bus.cmd_dst = '0;
    bus.cmd_len = '0;
    bus.cmd_fill = '0;
    for (int i = 0; i < N; i++) begin
      mdl_reg[i] = DW'($urandom);
      mdl_ram[i] = DW'($urandom);
    end
    mdl_ram[10] = 4'hA;
    mdl_ram[11] = 4'h3;
    @(negedge clk);
    cmp++;
    if ({bus.cmd_ready, bus.busy, bus.done, bus.aborted, bus.reg_rd, bus.reg_we, bus.ram_rd, bus.ram_we,
         bus.xfer_cnt, bus.ram_addr, bus.reg_waddr, bus.reg_wdata} !== {1'b1, 7'b0, 5'b0, 12'b0}) begin
      errs++;
      $display("FAIL reset: got ready=%b busy=%b done=%b we=%b%b rd=%b%b cnt=%0d, need ready=1 rest 0", bus.cmd_ready,
               bus.busy, bus.done, bus.reg_we, bus.ram_we, bus.reg_rd, bus.ram_rd, bus.xfer_cnt);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run(2'b10, 4'h0, 4'h5, 5'd3, 4'hF, -1, 1'b0);
    run(2'b00, 4'hA, 4'h1, 5'd2, 4'h0, -1, 1'b1);
    run(2'b01, 4'hE, 4'hF, 5'd3, 4'h0, -1, 1'b0);
    run(2'b11, 4'h2, 4'h7, 5'd0, 4'h6, 0, 1'b1);
    run(2'b00, 4'h4, 4'h9, 5'd4, 4'h0, PER + 1, 1'b0);
    run(2'b11, 4'h0, 4'hC, 5'd16, 4'h5, -1, 1'b1);
    run(2'b01, 4'h3, 4'h3, 5'd16, 4'h0, -1, 1'b0);
    run(2'b10, 4'h0, 4'h1, 5'd5, 4'h2, 5, 1'b0);
    for (int n = 0; n < 40; n++) begin
      logic [1:0] op;
      logic [AW:0] len;
      int t;
      op = 2'($urandom);
      len = (AW+1)'($urandom_range(0, 3) == 0 ? $urandom_range(0, N) : $urandom_range(0, 5));
      t = int'(len) * (op[1] ? 1 : PER);
      run(op, AW'($urandom), AW'($urandom), len, DW'($urandom),
          $urandom_range(0, 3) == 0 ? int'($urandom_range(0, t + 1)) : -1, 1'($urandom));
    end
    wait_ready(ok);
    if (ok) begin
      for (int i = 0; i < 2; i++) begin
        wr_t w;
        w.to_ram = 1'b0;
        w.a = AW'(3 + i);
        w.d = 4'h9;
        w.cyc = cyc + 1 + i;
        mdl_reg[3+i] = 4'h9;
        wq.push_back(w);
      end
      bus.cmd_valid = 1'b1;
      bus.cmd_op = 2'b10;
      bus.cmd_dst = 4'h3;
      bus.cmd_len = 5'd10;
      bus.cmd_fill = 4'h9;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      @(negedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      #1 cmp++;
      if ({bus.reg_we, bus.ram_we, bus.reg_rd, bus.ram_rd, bus.done, bus.busy, bus.cmd_ready} !== 7'b0000001) begin
        errs++;
        $display("FAIL midrst: got we=%b%b rd=%b%b done=%b busy=%b ready=%b, need strobes 0 ready=1",
                 bus.reg_we, bus.ram_we, bus.reg_rd, bus.ram_rd, bus.done, bus.busy, bus.cmd_ready);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
    end
    run(2'b00, 4'h3, 4'h0, 5'd3, 4'h0, -1, 1'b0);
    run(2'b11, 4'h0, 4'hE, 5'd4, 4'hB, 2, 1'b1);
    repeat (5) @(negedge clk);
    cmp++;
    if (wq.size() != 0 || eq.size() != 0) begin
      errs++;
      $display("FAIL leftover: got %0d writes %0d dones pending, need 0 and 0", wq.size(), eq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule
